onehot_arbiter: RTL and testbench

- Round-robin packet arbiter that merges `Count` valid/ready request streams into one output stream.
- Produces a registered one-hot grant vector. That vector steers the output data and is exported so downstream one-hot select logic can reuse it.
- Sits in front of shared resources: bus ports, shared FIFOs, response merge points.
- Holds a grant for a whole packet, delimited by `last`, then rotates priority.

---
 rtl/onehot_arbiter.sv | 109 ++++++++++
 tb/tb_onehot_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_arbiter.sv
// Round-robin packet arbiter: holds a registered one-hot grant for a whole packet
// (delimited by last) and rotates priority past the winner once the packet ends.
module onehot_arbiter #(
    parameter int unsigned Count = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Count-1:0] valid_i,
    input  logic [Count-1:0] last_i,
    input  logic [Width-1:0] data_i [Count],
    output logic [Count-1:0] ready_o,
    output logic             valid_o,
    output logic             last_o,
    output logic [Width-1:0] data_o,
    input  logic             ready_i,
    output logic [Count-1:0] grant_o
);

    localparam int unsigned PtrW = (Count > 1) ? $clog2(Count) : 1;

    typedef enum logic [0:0] {StIdle, StGranted} state_e;

    state_e           state_q, state_d;
    logic [Count-1:0] grant_q, grant_d;
    logic [PtrW-1:0]  ptr_q, ptr_d;

    logic [Count-1:0] pick_oh;
    logic             pick_found;
    logic [PtrW-1:0]  ptr_next;
    logic             xfer_last;

    // Scan ptr, ptr+1, ... wrapping; walking i downwards lets the lowest offset win.
    always_comb begin
        pick_oh    = '0;
        pick_found = 1'b0;
        for (int i = int'(Count) - 1; i >= 0; i--) begin
            for (int k = 0; k < int'(Count); k++) begin
                if (((k == int'(ptr_q) + i) || (k + int'(Count) == int'(ptr_q) + i)) &&
                    valid_i[k]) begin
                    pick_oh    = '0;
                    pick_oh[k] = 1'b1;
                    pick_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_next = '0;
        for (int k = 0; k < int'(Count); k++) begin
            if (grant_q[k]) begin
                ptr_next = (k + 1 < int'(Count)) ? PtrW'(k + 1) : '0;
            end
        end
    end

    // Output steering is purely combinational off the registered grant.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < int'(Count); k++) begin
            data_o = data_o | (data_i[k] & {Width{grant_q[k]}});
        end
        valid_o = |(valid_i & grant_q);
        last_o  = |(last_i & grant_q);
        ready_o = grant_q & {Count{ready_i}};
    end

    assign xfer_last = valid_o & ready_i & last_o;
    assign grant_o   = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_oh;
                    state_d = StGranted;
                end
            end
            StGranted: begin
                if (xfer_last) begin
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = StIdle;
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_onehot_arbiter.sv
// Directed bench for onehot_arbiter: a 4-requester instance checked every cycle against an
// index-based model plus literal expectations, and a 1-requester instance checked directly.
module tb_onehot_arbiter;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;

    // 4-requester instance
    logic [3:0] v4, l4, rdy4o, grant4;
    logic [7:0] d4 [4];
    logic       rdy, valid4o, last4o;
    logic [7:0] data4o;

    onehot_arbiter #(.Count(4), .Width(8)) u4 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .valid_i(v4),
        .last_i (l4),
        .data_i (d4),
        .ready_o(rdy4o),
        .valid_o(valid4o),
        .last_o (last4o),
        .data_o (data4o),
        .ready_i(rdy),
        .grant_o(grant4)
    );

    // 1-requester instance
    logic [0:0] v1, l1, rdy1o, grant1;
    logic [7:0] d1 [1];
    logic       valid1o, last1o;
    logic [7:0] data1o;

    onehot_arbiter #(.Count(1), .Width(8)) u1 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .valid_i(v1),
        .last_i (l1),
        .data_i (d1),
        .ready_o(rdy1o),
        .valid_o(valid1o),
        .last_o (last1o),
        .data_o (data1o),
        .ready_i(1'b1),
        .grant_o(grant1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Model: granted index (-1 when idle) and next priority index.
    int mg = -1;
    int mp = 0;

    always @(posedge clk_i or negedge rst_ni) begin
        int pick;
        if (!rst_ni) begin
            mg <= -1;
            mp <= 0;
        end else if (mg < 0) begin
            pick = -1;
            for (int j = 0; j < 4; j++) begin
                if (pick < 0 && v4[(mp + j) % 4]) pick = (mp + j) % 4;
            end
            mg <= pick;
        end else if (v4[mg] && rdy && l4[mg]) begin
            mg <= -1;
            mp <= (mg + 1) % 4;
        end
    end

    always @(negedge clk_i) begin
        logic [3:0] eg, er;
        logic       ev, el;
        logic [7:0] ed;
        eg = '0;
        er = '0;
        ev = 1'b0;
        el = 1'b0;
        ed = '0;
        if (mg >= 0) begin
            eg[mg] = 1'b1;
            ev     = v4[mg];
            el     = l4[mg];
            ed     = d4[mg];
            er     = rdy ? eg : 4'b0000;
        end
        chk("model_grant", 32'(grant4), 32'(eg));
        chk("model_valid", 32'(valid4o), 32'(ev));
        chk("model_last", 32'(last4o), 32'(el));
        chk("model_data", 32'(data4o), 32'(ed));
        chk("model_ready", 32'(rdy4o), 32'(er));
        chk("onehot0", 32'($onehot0(grant4)), 32'd1);
    end

    logic [3:0] rr_g [9];
    logic [7:0] rr_d [9];

    initial begin
        rr_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        rr_d = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00, 8'h44, 8'h00, 8'h11};
        v4 = 4'b1111;
        l4 = 4'b1111;
        rdy = 1'b1;
        for (int k = 0; k < 4; k++) d4[k] = 8'(8'h11 * (k + 1));
        v1 = 1'b0;
        l1 = 1'b0;
        d1[0] = 8'h00;
        #1 rst_ni = 1'b0;

        // Reset with every requester valid: everything stays quiet.
        tick(); #1;
        chk("rst_grant", 32'(grant4), 32'h0);
        chk("rst_valid", 32'(valid4o), 32'h0);
        chk("rst_ready", 32'(rdy4o), 32'h0);
        chk("rst_data", 32'(data4o), 32'h0);
        chk("rst_last", 32'(last4o), 32'h0);
        tick();
        rst_ni = 1'b1;

        // Round-robin with single-beat packets.
        for (int i = 0; i < 9; i++) begin
            tick(); #1;
            chk("rr_grant", 32'(grant4), 32'(rr_g[i]));
            chk("rr_data", 32'(data4o), 32'(rr_d[i]));
        end
        tick(); v4 = 4'b0000; #1;
        chk("rr_gap", 32'(grant4), 32'h0);

        // Packet hold: requester 2 sends three beats while 3 waits.
        tick(); v4 = 4'b1100; l4 = 4'b1000; d4[2] = 8'hB1; #1;
        chk("hold_idle", 32'(grant4), 32'h0);
        tick(); #1;
        chk("hold_g1", 32'(grant4), 32'b0100);
        chk("hold_d1", 32'(data4o), 32'hB1);
        chk("hold_l1", 32'(last4o), 32'h0);
        chk("hold_r1", 32'(rdy4o), 32'b0100);
        tick(); d4[2] = 8'hB2; #1;
        chk("hold_g2", 32'(grant4), 32'b0100);
        chk("hold_d2", 32'(data4o), 32'hB2);
        tick(); d4[2] = 8'hB3; l4[2] = 1'b1; #1;
        chk("hold_g3", 32'(grant4), 32'b0100);
        chk("hold_l3", 32'(last4o), 32'h1);
        tick(); #1;
        chk("hold_bubble", 32'(grant4), 32'h0);
        tick(); #1;
        chk("hold_next", 32'(grant4), 32'b1000);
        chk("hold_next_d", 32'(data4o), 32'h44);
        tick(); v4 = 4'b0000; l4 = 4'b0000; #1;
        chk("hold_end", 32'(grant4), 32'h0);

        // Backpressure on beat 2 of a 3-beat packet from requester 0.
        tick(); v4 = 4'b0001; d4[0] = 8'hC1; #1;
        chk("bp_idle", 32'(grant4), 32'h0);
        tick(); #1;
        chk("bp_g1", 32'(grant4), 32'b0001);
        chk("bp_d1", 32'(data4o), 32'hC1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                d4[0] = 8'hC2;
                rdy = 1'b0;
            end
            #1;
            chk("bp_hold_g", 32'(grant4), 32'b0001);
            chk("bp_hold_d", 32'(data4o), 32'hC2);
            chk("bp_hold_l", 32'(last4o), 32'h0);
            chk("bp_hold_r", 32'(rdy4o), 32'h0);
        end
        tick(); rdy = 1'b1; #1;
        chk("bp_resume_r", 32'(rdy4o), 32'b0001);
        chk("bp_resume_d", 32'(data4o), 32'hC2);
        tick(); d4[0] = 8'hC3; l4[0] = 1'b1; #1;
        chk("bp_g3", 32'(grant4), 32'b0001);
        chk("bp_l3", 32'(last4o), 32'h1);
        tick(); v4 = 4'b0000; l4 = 4'b0000; #1;
        chk("bp_end", 32'(grant4), 32'h0);

        // Reset during beat 2 of a 4-beat packet from requester 1.
        tick(); v4 = 4'b0010; d4[1] = 8'hD1; #1;
        chk("rm_idle", 32'(grant4), 32'h0);
        tick(); #1;
        chk("rm_g1", 32'(grant4), 32'b0010);
        tick(); d4[1] = 8'hD2; #1;
        chk("rm_g2", 32'(grant4), 32'b0010);
        chk("rm_d2", 32'(data4o), 32'hD2);
        #1 rst_ni = 1'b0;
        #1;
        chk("rm_async_g", 32'(grant4), 32'h0);
        chk("rm_async_v", 32'(valid4o), 32'h0);
        chk("rm_async_d", 32'(data4o), 32'h0);
        chk("rm_async_r", 32'(rdy4o), 32'h0);
        tick(); rst_ni = 1'b1; v4 = 4'b1001; l4 = 4'b1111; d4[0] = 8'h11; #1;
        chk("rm_held", 32'(grant4), 32'h0);
        tick(); #1;
        chk("rm_restart", 32'(grant4), 32'b0001);
        chk("rm_restart_d", 32'(data4o), 32'h11);
        tick(); v4 = 4'b0000; #1;
        chk("rm_end", 32'(grant4), 32'h0);

        // Requester drops valid mid-packet.
        tick(); v4 = 4'b0100; l4 = 4'b0000; d4[2] = 8'hE1; #1;
        chk("dv_idle", 32'(grant4), 32'h0);
        tick(); #1;
        chk("dv_g1", 32'(grant4), 32'b0100);
        chk("dv_v1", 32'(valid4o), 32'h1);
        tick(); v4 = 4'b0000; #1;
        chk("dv_drop_v", 32'(valid4o), 32'h0);
        chk("dv_drop_g", 32'(grant4), 32'b0100);
        chk("dv_drop_r", 32'(rdy4o), 32'b0100);
        tick(); #1;
        chk("dv_drop2_g", 32'(grant4), 32'b0100);
        tick(); v4 = 4'b0100; l4 = 4'b0100; d4[2] = 8'hE2; #1;
        chk("dv_back_v", 32'(valid4o), 32'h1);
        chk("dv_back_l", 32'(last4o), 32'h1);
        chk("dv_back_d", 32'(data4o), 32'hE2);
        tick(); v4 = 4'b0000; l4 = 4'b0000; #1;
        chk("dv_end", 32'(grant4), 32'h0);

        // Single requester: 2-beat packet, bubble, re-grant.
        tick(); v1 = 1'b1; l1 = 1'b0; d1[0] = 8'hF1; #1;
        chk("c1_idle", 32'(grant1), 32'h0);
        tick(); #1;
        chk("c1_g1", 32'(grant1), 32'h1);
        chk("c1_v1", 32'(valid1o), 32'h1);
        chk("c1_d1", 32'(data1o), 32'hF1);
        chk("c1_r1", 32'(rdy1o), 32'h1);
        tick(); l1 = 1'b1; d1[0] = 8'hF2; #1;
        chk("c1_g2", 32'(grant1), 32'h1);
        chk("c1_l2", 32'(last1o), 32'h1);
        chk("c1_d2", 32'(data1o), 32'hF2);
        tick(); d1[0] = 8'hF3; #1;
        chk("c1_bubble_g", 32'(grant1), 32'h0);
        chk("c1_bubble_v", 32'(valid1o), 32'h0);
        tick(); #1;
        chk("c1_regrant", 32'(grant1), 32'h1);
        chk("c1_regrant_d", 32'(data1o), 32'hF3);
        tick(); v1 = 1'b0; #1;
        chk("c1_end", 32'(grant1), 32'h0);

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
